// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_port_arbiter_pkg                                       |
// | Description : Shared definitions for the two-port memory arbiter.        |
// |               Holds the FSM state encoding, the owner codes and the      |
// |               legal range of the memory read latency.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package mem_port_arbiter_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t WAIT  = 2'd2;
    localparam state_t ACK   = 2'd3;

    // Owner codes, also the value of the owner output
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

    // Legal memory read latency range (bounded by the 4-bit wait counter)
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;

    // Counter preload for a given latency: the counter runs from lat-1 down
    // to zero, one WAIT cycle per value. Out-of-range values are clamped.
    function automatic logic [3:0] lat_load_value(input int lat);
        int v;
        v = lat;
        if (v < MEM_LAT_MIN) v = MEM_LAT_MIN;
        if (v > MEM_LAT_MAX) v = MEM_LAT_MAX;
        return 4'(v - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lat_counter                                                |
// | Description : Loadable down-counter with zero flag, used to time the     |
// |               memory read latency while the arbiter sits in WAIT.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    // Load has priority; decrement saturates at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - c_one;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                           |
// | Description : Arbitrates a single-port memory between the control unit   |
// |               (cpu_*) and the program loader (ldr_*). One transaction at |
// |               a time: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> ACK.     |
// |               Optional macro ARB_ROUND_ROBIN_EN: alternate grants on     |
// |               simultaneous requests (default: CPU always wins).          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy
);

    localparam logic [3:0] c_lat_load = lat_load_value(MEM_LAT);

    state_t            r_state;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_ldr_rdata;

    logic              w_start;
    logic              w_grant_ldr;
    logic              w_cnt_zero;
    logic              w_last_wait;

    assign w_start     = (r_state == IDLE) && (cpu_req || ldr_req);
    assign w_last_wait = (r_state == WAIT) && w_cnt_zero;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_winner;

    // On contention the grant goes to whoever lost the previous arbitration
    assign w_grant_ldr = ldr_req && (!cpu_req || (r_last_winner == OWN_CPU));

    // Remember the winner of every grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_winner <= OWN_LDR;
        end else if (w_start) begin
            r_last_winner <= w_grant_ldr ? OWN_LDR : OWN_CPU;
        end
    end
`else
    // Fixed priority: the CPU wins any contention
    assign w_grant_ldr = ldr_req && !cpu_req;
`endif

    // Transaction sequencer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_start) r_state <= ISSUE;
                ISSUE:   r_state <= WAIT;
                WAIT:    if (w_cnt_zero) r_state <= ACK;
                ACK:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Latch the winner's request; requester inputs are ignored until IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= OWN_CPU;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_start) begin
            r_owner <= w_grant_ldr ? OWN_LDR : OWN_CPU;
            r_we    <= w_grant_ldr ? ldr_we    : cpu_we;
            r_addr  <= w_grant_ldr ? ldr_addr  : cpu_addr;
            r_wdata <= w_grant_ldr ? ldr_wdata : cpu_wdata;
        end
    end

    // Capture read data into the owner's register; the other port holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
        end else if (w_last_wait) begin
            if (r_owner == OWN_LDR) r_ldr_rdata <= mem_rdata;
            else                    r_cpu_rdata <= mem_rdata;
        end
    end

    // Preloaded during ISSUE so WAIT lasts exactly MEM_LAT cycles
    lat_counter #(
        .CNT_W (4)
    ) u_lat_counter (
        .clk        (clk),
        .rst        (reset),
        .i_load     (r_state == ISSUE),
        .i_load_val (c_lat_load),
        .i_dec      (r_state == WAIT),
        .o_zero     (w_cnt_zero)
    );

    assign mem_en    = (r_state == ISSUE);
    assign mem_we    = (r_state == ISSUE) && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign cpu_ack   = (r_state == ACK) && (r_owner == OWN_CPU);
    assign ldr_ack   = (r_state == ACK) && (r_owner == OWN_LDR);
    assign cpu_rdata = r_cpu_rdata;
    assign ldr_rdata = r_ldr_rdata;
    assign owner     = r_owner;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire
